generate_last_split: RTL and testbench
======================================

Name: generate_last_split

Overview:
- Successor to the burst-length-driven last-flag generator.
- Merges a burst-length FIFO stream with a data-beat FIFO stream and emits data beats tagged with a last bit.
- Optionally splits long bursts into sub-bursts of at most MaxBurstLen beats, asserting last at each sub-burst boundary.
- Sits between the memory-write data path and the AXI W-channel adapter; sustains one beat per cycle with no bubble between bursts.

Parameters:
- DataWidth, 64, width of each data beat.
- BurstLenWidth, 8, width of the burst-length field; value encodes beats minus one.
- MaxBurstLen, 0, 0 = no splitting; otherwise last is forced every MaxBurstLen beats within a burst. Legal range 0 or 1..2**BurstLenWidth.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- burst_len_dout  input  BurstLenWidth  burst length minus one.
- burst_len_empty_n  input  1  burst length valid.
- burst_len_read  output  1  pop burst length.
- data_dout  input  DataWidth  data beat.
- data_empty_n  input  1  data beat valid.
- data_read  output  1  pop data beat.
- out_din  output  DataWidth+1  {last, data}; last is the MSB.
- out_full_n  input  1  output has space.
- out_write  output  1  push output beat.
- busy  output  1  high while a burst is partially emitted.

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst). All state updates on posedge clk.
- State: busy (IDLE = 0, BUSY = 1); remaining[BurstLenWidth] = beats left after the current beat; chunk = beats emitted in the current sub-burst, width clog2(MaxBurstLen)+1, unused when MaxBurstLen = 0.
- Reset: busy = 0, remaining = 0, chunk = 0. burst_len_read, data_read and out_write are 0 in every reset cycle regardless of inputs.
- Fire condition for a beat: data_empty_n & out_full_n, plus burst_len_empty_n when in IDLE. data_read = out_write = fire. out_din data field equals data_dout, combinationally, same cycle (zero latency). out_din is don't-care when out_write = 0; the bench must not check it then.
- IDLE fire:
  - burst_len_read = 1, len = burst_len_dout.
  - last = (len == 0) | (MaxBurstLen == 1).
  - remaining <= len; busy <= (len != 0).
  - chunk <= 0 if last, else 1.
  - burst_len_read is never asserted without a simultaneous data beat.
- BUSY fire:
  - cur = remaining - 1.
  - last = (cur == 0) | (MaxBurstLen != 0 & chunk == MaxBurstLen-1).
  - remaining <= cur; busy <= 0 when cur == 0.
  - chunk <= 0 if last, else chunk + 1.
- No fire: all state holds. Stall on any missing condition is a clean hold; no output pulses.
- Back-to-back bursts: the final beat of burst N (BUSY) and the first beat of burst N+1 (IDLE) occur in consecutive cycles. There is no idle cycle; throughput is 1 beat/cycle.
- Arithmetic: remaining never underflows, since a decrement occurs only when remaining != 0. Maximum burst 2**BurstLenWidth beats (len all-ones); no wrap.
- Split boundary: a sub-burst end coinciding with the burst end produces a single last, and chunk resets.
- Reset mid-burst: the remaining beats of that burst are dropped from tracking. Data beats still in the data FIFO are not consumed by this block. The next burst starts fresh from IDLE.
- busy output = busy register.

Test Plan:
- Single-beat bursts: burst lengths 0,0,0 with data A,B,C always available -> three consecutive out_write cycles, out_din = {1,A},{1,B},{1,C}; burst_len_read high in each cycle.
- Multi-beat then back-to-back: lengths 3,1, MaxBurstLen = 0 -> 6 contiguous beats with last pattern 0,0,0,1,0,1; burst_len_read on beats 1 and 5 only; busy high during beats 2-4 and beat 6.
- Splitting: MaxBurstLen = 4, length 9 (10 beats) -> last on beats 4, 8 and 10; chunk restarts after each last; exactly one burst_len_read.
- Backpressure and starvation: length 2; out_full_n low for 2 cycles mid-burst, then data_empty_n low for 1 cycle -> no out_write or data_read during stalls; beats emitted in order; last only on beat 3.
- Max length: BurstLenWidth = 4, length 15 -> 16 beats, last only on beat 16, no wrap; next length 0 accepted in the following cycle.
- Reset mid-burst: length 5, assert rst after beat 2 -> outputs 0 during reset; after release, length 0 with data D -> out_din = {1,D}; no residual beats attributed to the old burst.

Source files
------------

// File: rtl/generate_last_split.sv
// Merges a burst-length stream with a data-beat stream and tags each beat with last.
// Optional sub-burst splitting forces last every MaxBurstLen beats inside a burst.
module generate_last_split #(
    parameter int DataWidth     = 64,
    parameter int BurstLenWidth = 8,
    parameter int MaxBurstLen   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BurstLenWidth-1:0] burst_len_dout,
    input  logic                     burst_len_empty_n,
    output logic                     burst_len_read,
    input  logic [DataWidth-1:0]     data_dout,
    input  logic                     data_empty_n,
    output logic                     data_read,
    output logic [DataWidth:0]       out_din,
    input  logic                     out_full_n,
    output logic                     out_write,
    output logic                     busy
);

    localparam int ChunkWidth = $clog2(MaxBurstLen) + 1;
    localparam logic [ChunkWidth-1:0] ChunkMax =
        ChunkWidth'((MaxBurstLen > 0) ? (MaxBurstLen - 1) : 0);

    logic                     busy_q, busy_d;
    logic [BurstLenWidth-1:0] remaining_q, remaining_d;
    logic [ChunkWidth-1:0]    chunk_q, chunk_d;

    logic                     fire;
    logic                     last;
    logic                     split_hit;
    logic [BurstLenWidth-1:0] cur;
    logic [ChunkWidth-1:0]    chunk_cur;

    always_comb begin
        // Reset gates fire so no FIFO is popped or pushed while rst is held.
        fire      = data_empty_n & out_full_n & (busy_q | burst_len_empty_n) & ~rst;
        cur       = busy_q ? (remaining_q - 1'b1) : burst_len_dout;
        chunk_cur = busy_q ? chunk_q : '0;
        split_hit = (MaxBurstLen != 0) && (chunk_cur == ChunkMax);
        last      = (cur == '0) | split_hit;

        busy_d      = busy_q;
        remaining_d = remaining_q;
        chunk_d     = chunk_q;
        if (fire) begin
            remaining_d = cur;
            busy_d      = (cur != '0);
            chunk_d     = last ? '0 : (chunk_cur + 1'b1);
        end

        burst_len_read = fire & ~busy_q;
        data_read      = fire;
        out_write      = fire;
        out_din        = {last, data_dout};
        busy           = busy_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            remaining_q <= '0;
            chunk_q     <= '0;
        end else begin
            busy_q      <= busy_d;
            remaining_q <= remaining_d;
            chunk_q     <= chunk_d;
        end
    end

endmodule

// File: tb/tb_generate_last_split.sv
// Directed bench: three instances (no split, split by 4, 4-bit length) share one stimulus.
module tb_generate_last_split;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  bl;
    logic        bl_en;
    logic [63:0] dat;
    logic        dat_en;
    logic        full_n;

    logic        blr0, dr0, ow0, busy0;
    logic [64:0] od0;
    logic        blr1, dr1, ow1, busy1;
    logic [64:0] od1;
    logic        blr2, dr2, ow2, busy2;
    logic [64:0] od2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate_last_split #(.DataWidth(64), .BurstLenWidth(8), .MaxBurstLen(0)) u0 (
        .clk(clk), .rst(rst),
        .burst_len_dout(bl), .burst_len_empty_n(bl_en), .burst_len_read(blr0),
        .data_dout(dat), .data_empty_n(dat_en), .data_read(dr0),
        .out_din(od0), .out_full_n(full_n), .out_write(ow0), .busy(busy0));

    generate_last_split #(.DataWidth(64), .BurstLenWidth(8), .MaxBurstLen(4)) u1 (
        .clk(clk), .rst(rst),
        .burst_len_dout(bl), .burst_len_empty_n(bl_en), .burst_len_read(blr1),
        .data_dout(dat), .data_empty_n(dat_en), .data_read(dr1),
        .out_din(od1), .out_full_n(full_n), .out_write(ow1), .busy(busy1));

    generate_last_split #(.DataWidth(64), .BurstLenWidth(4), .MaxBurstLen(0)) u2 (
        .clk(clk), .rst(rst),
        .burst_len_dout(bl[3:0]), .burst_len_empty_n(bl_en), .burst_len_read(blr2),
        .data_dout(dat), .data_empty_n(dat_en), .data_read(dr2),
        .out_din(od2), .out_full_n(full_n), .out_write(ow2), .busy(busy2));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Apply inputs, then let combinational outputs settle before checks.
    task automatic drive(input logic [7:0] b, input logic be, input logic [63:0] d,
                         input logic de, input logic fn);
        bl = b; bl_en = be; dat = d; dat_en = de; full_n = fn;
        #1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(8'd0, 1'b0, 64'd0, 1'b0, 1'b1);
        next();
        rst = 1'b0;
    endtask

    initial begin
        int exp_last2[6] = '{0, 0, 0, 1, 0, 1};
        int exp_blr2[6]  = '{1, 0, 0, 0, 1, 0};
        int exp_busy2[6] = '{0, 1, 1, 1, 0, 1};

        // Reset cycle with every input asserted: nothing may fire.
        rst = 1'b1;
        drive(8'd0, 1'b1, 64'h55, 1'b1, 1'b1);
        chk("rst_ow", ow0, 0);
        chk("rst_dr", dr0, 0);
        chk("rst_blr", blr0, 0);
        chk("rst_busy", busy0, 0);
        next();
        rst = 1'b0;

        // Single-beat bursts A,B,C back to back.
        for (int k = 0; k < 3; k++) begin
            drive(8'd0, 1'b1, 64'hA0 + 64'(k), 1'b1, 1'b1);
            chk("single_ow", ow0, 1);
            chk("single_blr", blr0, 1);
            chk("single_din", od0, {1'b1, 64'hA0 + 64'(k)});
            next();
        end
        do_reset();

        // Length 3 then length 1, contiguous.
        for (int k = 0; k < 6; k++) begin
            drive((k < 4) ? 8'd3 : 8'd1, 1'b1, 64'd100 + 64'(k), 1'b1, 1'b1);
            chk("b2b_ow", ow0, 1);
            chk("b2b_blr", blr0, exp_blr2[k][0]);
            chk("b2b_busy", busy0, exp_busy2[k][0]);
            chk("b2b_din", od0, {exp_last2[k][0], 64'd100 + 64'(k)});
            next();
        end
        drive(8'd0, 1'b0, 64'd0, 1'b1, 1'b1);
        chk("b2b_idle_ow", ow0, 0);
        chk("b2b_idle_busy", busy0, 0);
        do_reset();

        // Split by 4: length 9 gives last on beats 4, 8, 10.
        for (int k = 1; k <= 10; k++) begin
            drive(8'd9, (k == 1), 64'd200 + 64'(k), 1'b1, 1'b1);
            chk("split_ow", ow1, 1);
            chk("split_blr", blr1, (k == 1));
            chk("split_last", od1[64], (k == 4) || (k == 8) || (k == 10));
            next();
        end
        drive(8'd0, 1'b0, 64'd0, 1'b1, 1'b1);
        chk("split_idle_busy", busy1, 0);
        do_reset();

        // Backpressure then starvation on a length-2 burst.
        drive(8'd2, 1'b1, 64'd301, 1'b1, 1'b1);
        chk("bp_b1_ow", ow0, 1);
        chk("bp_b1_blr", blr0, 1);
        chk("bp_b1_din", od0, {1'b0, 64'd301});
        next();
        for (int k = 0; k < 2; k++) begin
            drive(8'd0, 1'b0, 64'd302, 1'b1, 1'b0);
            chk("bp_full_ow", ow0, 0);
            chk("bp_full_dr", dr0, 0);
            next();
        end
        drive(8'd0, 1'b0, 64'd302, 1'b1, 1'b1);
        chk("bp_b2_din", od0, {1'b0, 64'd302});
        chk("bp_b2_ow", ow0, 1);
        next();
        drive(8'd0, 1'b0, 64'd303, 1'b0, 1'b1);
        chk("bp_empty_ow", ow0, 0);
        chk("bp_empty_dr", dr0, 0);
        next();
        drive(8'd0, 1'b0, 64'd303, 1'b1, 1'b1);
        chk("bp_b3_ow", ow0, 1);
        chk("bp_b3_din", od0, {1'b1, 64'd303});
        next();
        drive(8'd0, 1'b0, 64'd0, 1'b1, 1'b1);
        chk("bp_end_busy", busy0, 0);
        do_reset();

        // 4-bit length 15: 16 beats, then a length-0 burst straight after.
        for (int k = 1; k <= 16; k++) begin
            drive(8'd15, (k == 1), 64'd400 + 64'(k), 1'b1, 1'b1);
            chk("max_ow", ow2, 1);
            chk("max_last", od2[64], (k == 16));
            next();
        end
        drive(8'd0, 1'b1, 64'd500, 1'b1, 1'b1);
        chk("max_next_blr", blr2, 1);
        chk("max_next_din", od2, {1'b1, 64'd500});
        next();
        do_reset();

        // Reset after beat 2 of a length-5 burst.
        for (int k = 1; k <= 2; k++) begin
            drive(8'd5, (k == 1), 64'd600 + 64'(k), 1'b1, 1'b1);
            chk("rmid_ow", ow0, 1);
            next();
        end
        chk("rmid_busy", busy0, 1);
        rst = 1'b1;
        drive(8'd0, 1'b1, 64'd699, 1'b1, 1'b1);
        chk("rmid_rst_ow", ow0, 0);
        chk("rmid_rst_dr", dr0, 0);
        chk("rmid_rst_blr", blr0, 0);
        next();
        rst = 1'b0;
        drive(8'd0, 1'b1, 64'hD, 1'b1, 1'b1);
        chk("rmid_busy_after", busy0, 0);
        chk("rmid_blr", blr0, 1);
        chk("rmid_din", od0, {1'b1, 64'hD});
        next();
        drive(8'd0, 1'b0, 64'hE, 1'b1, 1'b1);
        chk("rmid_residual_ow", ow0, 0);
        chk("rmid_residual_busy", busy0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
